cskip_adder_pipe: RTL and testbench

CSKIP_ADDER_PIPE -- requirements
Module: cskip_adder_pipe

---
 rtl/cskip_pkg.sv | 34 +++
 rtl/cskip_group.sv | 44 ++++
 rtl/cskip_adder_pipe.sv | 123 ++++++++++++
 tb/tb_cskip_adder_pipe.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cskip_pkg.sv
// Shared constants, config helpers and the per-stage pipeline record for the carry-skip adder.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a. Optional ovf field is present only when CSKIP_ADDER_OVF_EN is defined.
package cskip_pkg;

    // Record fields are sized for the largest supported operand; stages use the low bits.
    localparam int CSKIP_MAX_W    = 64;
    localparam int CSKIP_MAX_NGRP = 32;

    function automatic int cskip_ngrp(input int width, input int blk);
        return width / blk;
    endfunction

    function automatic bit cskip_cfg_ok(input int width, input int blk);
        return (blk >= 2) && ((width % blk) == 0) && (width <= CSKIP_MAX_W)
               && ((width / blk) <= CSKIP_MAX_NGRP);
    endfunction

    // One beat travelling down the pipe: resolved low sum bits, carry out of the last
    // resolved group, the operand bits still waiting (shifted down so the next group
    // always sits at bit 0), and the skip flags collected so far.
    typedef struct packed {
        logic                      vld;
        logic                      carry;
`ifdef CSKIP_ADDER_OVF_EN
        logic                      ovf;
`endif
        logic [CSKIP_MAX_W-1:0]    sum;
        logic [CSKIP_MAX_W-1:0]    rem_a;
        logic [CSKIP_MAX_W-1:0]    rem_b;
        logic [CSKIP_MAX_NGRP-1:0] skip;
    } stage_t;

endpackage

// File: rtl/cskip_group.sv
// One skip group: BLK-bit ripple adder, all-propagate detect and carry bypass mux.
// Latency: purely combinational.
// Backpressure: none; the enclosing pipeline stage owns flow control. c_msb exists with CSKIP_ADDER_OVF_EN.
module cskip_group #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           cout,
    output logic           all_p
`ifdef CSKIP_ADDER_OVF_EN
    ,
    output logic           c_msb
`endif
);

    logic [BLK-1:0] p;
    logic           rc;

    assign p     = a ^ b;
    assign all_p = &p;

    // Ripple the carry through the group; rc ends as the ripple carry-out.
    always_comb begin
        rc  = cin;
        sum = '0;
`ifdef CSKIP_ADDER_OVF_EN
        c_msb = cin;
`endif
        for (int i = 0; i < BLK; i++) begin
`ifdef CSKIP_ADDER_OVF_EN
            c_msb = rc;
`endif
            sum[i] = p[i] ^ rc;
            rc     = (a[i] & b[i]) | (p[i] & rc);
        end
    end

    // When every bit propagates the incoming carry passes straight through.
    assign cout = all_p ? cin : rc;

endmodule

// File: rtl/cskip_adder_pipe.sv
// Pipelined carry-skip adder/subtractor resolving one BLK-bit group per stage, LSB group first.
// Latency: NGRP cycles, one beat per cycle. Optional ovf output with CSKIP_ADDER_OVF_EN.
// Backpressure: whole pipe advances only when !out_valid || out_ready; in_ready mirrors that.
module cskip_adder_pipe
    import cskip_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic                   cin,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       sum,
    output logic                   cout,
    output logic [WIDTH/BLK-1:0]   skip_mask
`ifdef CSKIP_ADDER_OVF_EN
    ,
    output logic                   ovf
`endif
);

    localparam int NGRP = cskip_ngrp(WIDTH, BLK);

    if (!cskip_cfg_ok(WIDTH, BLK)) begin : g_bad_cfg
        $error("cskip_adder_pipe: WIDTH must be a multiple of BLK, BLK >= 2, WIDTH <= 64");
    end

    stage_t st_q [NGRP];
    stage_t st_d [NGRP];
    stage_t in_rec;
    logic   adv;

    assign out_valid = st_q[NGRP-1].vld;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    // Build the record entering group 0; subtraction inverts B and forces the carry-in.
    always_comb begin
        in_rec       = '0;
        in_rec.vld   = in_valid;
        in_rec.carry = sub ? 1'b1 : cin;
        in_rec.rem_a = CSKIP_MAX_W'(a);
        in_rec.rem_b = CSKIP_MAX_W'(sub ? ~b : b);
    end

    for (genvar g = 0; g < NGRP; g++) begin : g_stage
        stage_t         rec_in;
        stage_t         rec_d;
        logic [BLK-1:0] grp_sum;
        logic           grp_cout;
        logic           grp_skip;
`ifdef CSKIP_ADDER_OVF_EN
        logic           grp_cmsb;
`endif

        if (g == 0) begin : g_head
            assign rec_in = in_rec;
        end else begin : g_body
            assign rec_in = st_q[g-1];
        end

        cskip_group #(.BLK(BLK)) u_grp (
            .a     (rec_in.rem_a[BLK-1:0]),
            .b     (rec_in.rem_b[BLK-1:0]),
            .cin   (rec_in.carry),
            .sum   (grp_sum),
            .cout  (grp_cout),
            .all_p (grp_skip)
`ifdef CSKIP_ADDER_OVF_EN
            ,
            .c_msb (grp_cmsb)
`endif
        );

        // Fold this group's result into the record and shift the unresolved operand bits down.
        always_comb begin
            rec_d       = rec_in;
            rec_d.carry = grp_cout;
            rec_d.sum   = rec_in.sum | (CSKIP_MAX_W'(grp_sum) << (g * BLK));
            rec_d.rem_a = rec_in.rem_a >> BLK;
            rec_d.rem_b = rec_in.rem_b >> BLK;
            rec_d.skip  = rec_in.skip | (CSKIP_MAX_NGRP'(grp_skip) << g);
`ifdef CSKIP_ADDER_OVF_EN
            // Only the last group's value survives to the output: carry into MSB xor carry out.
            rec_d.ovf   = grp_cmsb ^ grp_cout;
`endif
        end

        assign st_d[g] = rec_d;
    end

    // The whole pipe moves together on adv; reset drops every in-flight beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < NGRP; g++) begin
                st_q[g] <= '0;
            end
        end else if (adv) begin
            for (int g = 0; g < NGRP; g++) begin
                st_q[g] <= st_d[g];
            end
        end
    end

    assign sum       = st_q[NGRP-1].sum[WIDTH-1:0];
    assign cout      = st_q[NGRP-1].carry;
    assign skip_mask = st_q[NGRP-1].skip[NGRP-1:0];
`ifdef CSKIP_ADDER_OVF_EN
    assign ovf       = st_q[NGRP-1].ovf;
`endif

    // Spare record bits at the tail (drained operands, unused high lanes) go nowhere.
    logic unused_tail;
    assign unused_tail = ^st_q[NGRP-1];

endmodule

// File: tb/tb_cskip_adder_pipe.sv
module tb_cskip_adder_pipe;

    localparam int W  = 16;
    localparam int B  = 4;
    localparam int NG = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cin = 1'b0;
    logic          sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  sum;
    logic          cout;
    logic [NG-1:0] skip_mask;
`ifdef CSKIP_ADDER_OVF_EN
    logic          ovf;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int n_out  = 0;

    always #5 clk = ~clk;

    cskip_adder_pipe #(.WIDTH(W), .BLK(B)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .skip_mask (skip_mask)
`ifdef CSKIP_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic [3:0]  mask;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    // Reference: plain 17-bit arithmetic plus per-nibble propagate test.
    function automatic exp_t model(logic [15:0] ma, logic [15:0] mb, logic mcin, logic msub);
        logic [15:0] beff;
        logic [15:0] p;
        logic [16:0] tot;
        logic [3:0]  nib;
        exp_t        e;
        beff   = msub ? ~mb : mb;
        tot    = {1'b0, ma} + {1'b0, beff} + (msub ? 17'd1 : {16'd0, mcin});
        e.sum  = tot[15:0];
        e.cout = tot[16];
        p      = ma ^ beff;
        for (int g = 0; g < 4; g++) begin
            nib       = p[4*g +: 4];
            e.mask[g] = (nib == 4'hF);
        end
        e.ovf = (ma[15] == beff[15]) && (tot[15] != ma[15]);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Compare process: scoreboard push/pop on handshakes and hold-stability during stalls.
    initial begin
        exp_t        e;
        logic        prev_stall;
        logic [15:0] p_sum;
        logic        p_cout;
        logic [3:0]  p_mask;
        prev_stall = 1'b0;
        p_sum  = '0;
        p_cout = 1'b0;
        p_mask = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid_hold", 32'(out_valid), 32'd1);
                    check("stall_sum_hold",   32'(sum),       32'(p_sum));
                    check("stall_cout_hold",  32'(cout),      32'(p_cout));
                    check("stall_mask_hold",  32'(skip_mask), 32'(p_mask));
                end
                if (out_valid && out_ready) begin
                    n_out++;
                    if (sb.size() == 0) begin
                        check("unexpected_beat", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("sb_sum",  32'(sum),       32'(e.sum));
                        check("sb_cout", 32'(cout),      32'(e.cout));
                        check("sb_mask", 32'(skip_mask), 32'(e.mask));
`ifdef CSKIP_ADDER_OVF_EN
                        check("sb_ovf",  32'(ovf),       32'(e.ovf));
`endif
                    end
                end
                if (in_valid && in_ready) begin
                    sb.push_back(model(a, b, cin, sub));
                end
                prev_stall = out_valid && !out_ready;
                p_sum  = sum;
                p_cout = cout;
                p_mask = skip_mask;
            end
        end
    end

    // Single beat into an idle pipe; checks latency and literal results.
    task automatic run_one(input string name, input logic [15:0] ta, input logic [15:0] tbv,
                           input logic tcin, input logic tsub,
                           input logic [15:0] es, input logic ec, input logic [3:0] em);
        int lat;
        a = ta; b = tbv; cin = tcin; sub = tsub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, 32'(lat),       32'd4);
        check({name, "_sum"},     32'(sum),       32'(es));
        check({name, "_cout"},    32'(cout),      32'(ec));
        check({name, "_mask"},    32'(skip_mask), 32'(em));
    endtask

    task automatic rand_beat();
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    initial begin
        int sent;
        int k;
        int ghost;
        int out0;
        int waitc;

        // Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_cout",      32'(cout),      32'd0);
        check("rst_mask",      32'(skip_mask), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
`ifdef CSKIP_ADDER_OVF_EN
        check("rst_ovf",       32'(ovf),       32'd0);
`endif
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Hand-computed directed cases.
        run_one("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 4'b1110);
        run_one("sub5m7",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 4'b1110);
        run_one("fullskip", 16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 4'b1111);
`ifdef CSKIP_ADDER_OVF_EN
        run_one("ovf",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 4'b0110);
        check("ovf_flag", 32'(ovf), 32'd1);
`endif
        @(posedge clk); #1;

        // Back-to-back stream of 10 beats with a 3-cycle output stall mid-stream.
        out0 = n_out;
        sent = 0;
        k    = 0;
        rand_beat();
        in_valid = 1'b1;
        while (sent < 10 && k < 100) begin
            out_ready = !(k >= 6 && k < 9);
            @(negedge clk);
            if (k >= 6 && k < 9) check("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            if (in_ready || (k >= 6 && k < 9 && 1'b0)) begin end
            k++;
            if (in_valid && dut.in_ready === 1'b1) begin end
            if (!(k - 1 >= 6 && k - 1 < 9)) begin
                sent++;
                if (sent < 10) rand_beat();
                else in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitc = 0;
        while (sb.size() != 0 && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        @(negedge clk);
        check("stream_drained", 32'(sb.size()), 32'd0);
        check("stream_count",   32'(n_out - out0), 32'd10);
        @(posedge clk); #1;

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            rand_beat();
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        check("midrst_out_valid_next", 32'(out_valid), 32'd0);
        rst = 1'b0;
        ghost = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) ghost++;
        end
        check("midrst_no_ghost", 32'(ghost), 32'd0);
        run_one("after_rst", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 4'b0000);
        @(posedge clk); #1;

        // Random traffic with random bubbles and backpressure.
        for (int i = 0; i < 400; i++) begin
            rand_beat();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitc = 0;
        while (sb.size() != 0 && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        @(negedge clk);
        check("random_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
